prog_mem_loader: RTL and testbench

// - Parametrised instruction memory with a streaming load port and built-in core-reset sequencing.
// - Replaces backdoor hex preloading of instruction memory.
// - Program words stream in over a valid/ready port. The block holds the core in reset until
//   the image is complete, then serves synchronous fetches from riscv_core.
// - Also usable as a boot ROM front-end when fed by a UART/JTAG bridge.

---
 rtl/prog_mem_loader.sv | 135 +++++++++++++
 tb/tb_prog_mem_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/prog_mem_loader.sv
// Instruction memory with a streaming valid/ready load port and core-reset sequencing.
// Optional running checksum of the loaded image: define PROG_MEM_CKSUM_EN.
module prog_mem_loader #(
   parameter int ADDR_W                 = 10,
   parameter int XLEN                   = 32,
   parameter int RELEASE_DELAY          = 4,
   parameter logic [XLEN-1:0] NOP_WORD  = XLEN'(32'h0000_0013)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [XLEN-1:0]   load_data,
   input  logic              load_last,
   input  logic              reload,
   output logic              core_rst_n,
   input  logic [XLEN-1:0]   fetch_addr,
   output logic [XLEN-1:0]   fetch_instr,
   output logic              fetch_misalign,
   output logic [ADDR_W:0]   loaded_words,
   output logic              overflow,
   output logic [XLEN-1:0]   load_cksum
);

   // state | meaning
   // LOAD  | accepting image words, core held in reset
   // HOLD  | image complete, release delay counting down
   // RUN   | core out of reset, serving fetches
   localparam logic [1:0] ST_LOAD = 2'd0;
   localparam logic [1:0] ST_HOLD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   localparam int SIZE  = 1 << ADDR_W;
   localparam int CNT_W = (RELEASE_DELAY < 1) ? 1 : $clog2(RELEASE_DELAY + 1);
   localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(RELEASE_DELAY);
   localparam logic [ADDR_W-1:0] PTR_LAST  = {ADDR_W{1'b1}};
   localparam logic [ADDR_W:0]   WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};

   logic [1:0]         state;
   logic [ADDR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]   hold_cnt;
   logic [XLEN-1:0]    mem [SIZE];
   logic               accept;
   logic               reload_ok;
   logic               misalign_now;
   logic [ADDR_W-1:0]  rd_idx;
   logic               unused_addr_bits;

   assign load_ready   = (state == ST_LOAD);
   assign accept       = load_valid & load_ready;
   assign reload_ok    = reload & (state != ST_LOAD);
   assign rd_idx       = fetch_addr[ADDR_W+1:2];
   assign misalign_now = |fetch_addr[1:0];

   // Upper PC bits alias onto the memory.
   assign unused_addr_bits = ^fetch_addr[XLEN-1:ADDR_W+2];

   always_ff @(posedge clk) begin
      if (accept)
         mem[wr_ptr] <= load_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_LOAD;
         wr_ptr       <= '0;
         hold_cnt     <= '0;
         core_rst_n   <= 1'b0;
         loaded_words <= '0;
         overflow     <= 1'b0;
      end else if (reload_ok) begin
         state        <= ST_LOAD;
         wr_ptr       <= '0;
         hold_cnt     <= '0;
         core_rst_n   <= 1'b0;
         loaded_words <= '0;
         overflow     <= 1'b0;
      end else begin
         case (state)
            ST_LOAD: begin
               if (accept) begin
                  wr_ptr <= wr_ptr + 1'b1;
                  if (loaded_words != WORDS_MAX)
                     loaded_words <= loaded_words + 1'b1;
                  // The final slot ends the image even without load_last; no wrap.
                  if (load_last || (wr_ptr == PTR_LAST)) begin
                     state    <= ST_HOLD;
                     hold_cnt <= CNT_INIT;
                  end
                  if (!load_last && (wr_ptr == PTR_LAST))
                     overflow <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (hold_cnt == '0) begin
                  state      <= ST_RUN;
                  core_rst_n <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt - 1'b1;
               end
            end
            ST_RUN: begin
            end
            default: state <= ST_LOAD;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_instr    <= NOP_WORD;
         fetch_misalign <= 1'b0;
      end else if (state == ST_RUN) begin
         fetch_instr    <= misalign_now ? NOP_WORD : mem[rd_idx];
         fetch_misalign <= misalign_now;
      end else begin
         fetch_instr    <= NOP_WORD;
         fetch_misalign <= 1'b0;
      end
   end

`ifdef PROG_MEM_CKSUM_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         load_cksum <= '0;
      else if (reload_ok)
         load_cksum <= '0;
      else if (accept)
         load_cksum <= load_cksum + load_data;
   end
`else
   assign load_cksum = '0;
`endif

endmodule

// File: tb/tb_prog_mem_loader.sv
// Bench for prog_mem_loader: ADDR_W=4 so the overflow case is reachable, RELEASE_DELAY=4.
module tb_prog_mem_loader;

   localparam int ADDR_W = 4;
   localparam int XLEN   = 32;
   localparam int RD     = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              load_valid = 1'b0;
   logic              load_ready;
   logic [XLEN-1:0]   load_data = '0;
   logic              load_last = 1'b0;
   logic              reload = 1'b0;
   logic              core_rst_n;
   logic [XLEN-1:0]   fetch_addr = '0;
   logic [XLEN-1:0]   fetch_instr;
   logic              fetch_misalign;
   logic [ADDR_W:0]   loaded_words;
   logic              overflow;
   logic [XLEN-1:0]   load_cksum;

   prog_mem_loader #(.ADDR_W(ADDR_W), .XLEN(XLEN), .RELEASE_DELAY(RD), .NOP_WORD(NOP)) dut (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
      .load_data(load_data), .load_last(load_last), .reload(reload),
      .core_rst_n(core_rst_n), .fetch_addr(fetch_addr), .fetch_instr(fetch_instr),
      .fetch_misalign(fetch_misalign), .loaded_words(loaded_words),
      .overflow(overflow), .load_cksum(load_cksum)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] instr;
      logic        mis;
   } fvec_t;

   fvec_t       tbl[$];
   fvec_t       exp_q[$];
   int          n_vec = 0;
   int          n_bad = 0;
   logic [31:0] ck_exp = '0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic add(input logic [31:0] a, input logic [31:0] i, input logic m);
      fvec_t v;
      v.addr = a; v.instr = i; v.mis = m;
      tbl.push_back(v);
   endtask

   task automatic run_tbl();
      fvec_t e;
      foreach (tbl[i]) begin
         fetch_addr = tbl[i].addr;
         exp_q.push_back(tbl[i]);
         tick();
         e = exp_q.pop_front();
         check($sformatf("fetch_instr@%0h", e.addr), fetch_instr, e.instr);
         check($sformatf("fetch_mis@%0h", e.addr), {31'b0, fetch_misalign}, {31'b0, e.mis});
      end
      tbl.delete();
   endtask

   task automatic send(input logic [31:0] d, input logic last);
      check("load_ready_pre", {31'b0, load_ready}, 32'd1);
      load_valid = 1'b1; load_data = d; load_last = last;
      tick();
`ifdef PROG_MEM_CKSUM_EN
      ck_exp = ck_exp + d;
`endif
      load_valid = 1'b0; load_last = 1'b0;
      check("load_cksum", load_cksum, ck_exp);
   endtask

   task automatic wait_release();
      int cyc = 0;
      while (core_rst_n !== 1'b1 && cyc < 20) begin
         tick();
         cyc++;
      end
      check("release_cycles", cyc, RD + 1);
   endtask

   task automatic do_reload(input logic with_valid);
      reload = 1'b1; load_valid = with_valid; load_data = 32'h0BAD_0BAD;
      tick();
      reload = 1'b0; load_valid = 1'b0;
      ck_exp = '0;
      check("reload_core_rst_n", {31'b0, core_rst_n}, 32'd0);
      check("reload_loaded_words", {27'b0, loaded_words}, 32'd0);
      check("reload_overflow", {31'b0, overflow}, 32'd0);
      check("reload_load_ready", {31'b0, load_ready}, 32'd1);
      check("reload_cksum", load_cksum, 32'd0);
   endtask

   initial begin
      fvec_t run_vec[8];
      logic [31:0] w[3];
      w[0] = 32'h0050_0093; w[1] = 32'h0010_8113; w[2] = 32'h0000_006F;
      run_vec[0] = '{32'h0,  w[0],         1'b0};
      run_vec[1] = '{32'h4,  w[1],         1'b0};
      run_vec[2] = '{32'h8,  w[2],         1'b0};
      run_vec[3] = '{32'hC,  32'hA000_0003, 1'b0};
      run_vec[4] = '{32'h6,  NOP,          1'b1};
      run_vec[5] = '{32'h1,  NOP,          1'b1};
      run_vec[6] = '{32'h48, w[2],         1'b0};
      run_vec[7] = '{32'h3C, 32'hA000_000F, 1'b0};

      // Reset values
      tick(); tick();
      rst = 1'b0;
      check("rst_load_ready", {31'b0, load_ready}, 32'd1);
      check("rst_core_rst_n", {31'b0, core_rst_n}, 32'd0);
      check("rst_fetch_instr", fetch_instr, NOP);
      check("rst_fetch_mis", {31'b0, fetch_misalign}, 32'd0);
      check("rst_loaded_words", {27'b0, loaded_words}, 32'd0);
      check("rst_overflow", {31'b0, overflow}, 32'd0);
      check("rst_cksum", load_cksum, 32'd0);
      add(32'h4, NOP, 1'b0);
      run_tbl();

      // Overflow: 16 words with no load_last, then a 17th held on the port
      for (int i = 0; i < 16; i++)
         send(32'hA000_0000 + i, 1'b0);
      load_valid = 1'b1; load_data = 32'h0BAD_F00D;
      check("ovf_overflow", {31'b0, overflow}, 32'd1);
      check("ovf_loaded_words", {27'b0, loaded_words}, 32'd16);
      check("ovf_load_ready", {31'b0, load_ready}, 32'd0);
      wait_release();
      check("ovf_loaded_words_run", {27'b0, loaded_words}, 32'd16);
      add(32'h0, 32'hA000_0000, 1'b0);
      add(32'h3C, 32'hA000_000F, 1'b0);
      run_tbl();
      load_valid = 1'b0;

      // reload in RUN with load_valid, then 1-word image
      do_reload(1'b1);
      send(32'h0000_1111, 1'b1);
      check("one_loaded_words", {27'b0, loaded_words}, 32'd1);
      wait_release();
      add(32'h0, 32'h0000_1111, 1'b0);
      add(32'h4, 32'hA000_0001, 1'b0);
      run_tbl();

      // 3-word image with random gaps, load_valid then held through HOLD/RUN
      do_reload(1'b0);
      for (int i = 0; i < 3; i++) begin
         send(w[i], i == 2);
         if (i < 2) repeat ($urandom_range(0, 2)) tick();
      end
      load_valid = 1'b1; load_data = 32'hDEAD_BEEF;
      check("img_loaded_words", {27'b0, loaded_words}, 32'd3);
      check("img_load_ready_hold", {31'b0, load_ready}, 32'd0);
      wait_release();
      check("img_load_ready_run", {31'b0, load_ready}, 32'd0);
      foreach (run_vec[i]) tbl.push_back(run_vec[i]);
      run_tbl();
      check("img_loaded_words_run", {27'b0, loaded_words}, 32'd3);
      load_valid = 1'b0;

      // Checksum wrap
      do_reload(1'b0);
      send(32'hFFFF_FFFF, 1'b0);
      send(32'h0000_0002, 1'b1);
      wait_release();

      // Async reset between edges in LOAD
      do_reload(1'b0);
      send(32'h1234_5678, 1'b0);
      #3 rst = 1'b1;
      #1;
      ck_exp = '0;
      check("arst_loaded_words", {27'b0, loaded_words}, 32'd0);
      check("arst_load_ready", {31'b0, load_ready}, 32'd1);
      check("arst_core_rst_n", {31'b0, core_rst_n}, 32'd0);
      check("arst_cksum", load_cksum, 32'd0);
      check("arst_fetch_instr", fetch_instr, NOP);
      #2 rst = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
